// File: rtl/step3_action_select.sv
// PBVI backup final stage: per belief point, pick the action whose alpha vector maximises dot(alpha, belief).
// Optional macro STEP3_VALUE_OUT_EN adds point_value, the winning dot per point.
module step3_action_select #(
    parameter int N_ACTION = 3,
    parameter int N_POINT  = 16,
    parameter int N_STATE  = 2,
    parameter int W        = 16,
    localparam int AW = (N_ACTION > 1) ? $clog2(N_ACTION) : 1,
    localparam int PW = (N_POINT > 1) ? $clog2(N_POINT) : 1,
    localparam int DW = 2 * W + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_step3,
    input  logic [W-1:0]  gamma_action_bilief [N_ACTION][N_POINT][N_STATE],
    input  logic [W-1:0]  point_belief [N_POINT][N_STATE],
    output logic [W-1:0]  alpha_out [N_POINT][N_STATE],
    output logic [AW-1:0] action_out [N_POINT],
`ifdef STEP3_VALUE_OUT_EN
    output logic signed [DW-1:0] point_value [N_POINT],
`endif
    output logic          busy,
    output logic          en_loop
);

    localparam int PRW = 2 * W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        p_q, p_d;
    logic [AW-1:0]        a_q, a_d;
    logic signed [DW-1:0] best_val_q, best_val_d;
    logic [AW-1:0]        best_act_q, best_act_d;
    logic                 busy_q, busy_d;
    logic                 en_loop_q, en_loop_d;
    logic [W-1:0]         alpha_out_q [N_POINT][N_STATE];
    logic [W-1:0]         alpha_out_d [N_POINT][N_STATE];
    logic [AW-1:0]        action_out_q [N_POINT];
    logic [AW-1:0]        action_out_d [N_POINT];
`ifdef STEP3_VALUE_OUT_EN
    logic signed [DW-1:0] point_value_q [N_POINT];
    logic signed [DW-1:0] point_value_d [N_POINT];
`endif

    logic signed [PRW-1:0] prod;
    logic signed [DW-1:0]  dot;
    logic                  take;
    logic signed [DW-1:0]  win_val;
    logic [AW-1:0]         win_act;

    // Dot product of the current (p,a) candidate with belief[p]; belief is unsigned Q0.16.
    always_comb begin
        prod = '0;
        dot  = '0;
        for (int unsigned s = 0; s < N_STATE; s++) begin
            prod = $signed(gamma_action_bilief[a_q][p_q][s]) * $signed({1'b0, point_belief[p_q][s]});
            dot  = dot + {{(DW - PRW){prod[PRW-1]}}, prod};
        end
        take    = (a_q == '0) || (dot > best_val_q);
        win_val = take ? dot : best_val_q;
        win_act = take ? a_q : best_act_q;
    end

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        a_d          = a_q;
        best_val_d   = best_val_q;
        best_act_d   = best_act_q;
        busy_d       = busy_q;
        en_loop_d    = 1'b0;
        alpha_out_d  = alpha_out_q;
        action_out_d = action_out_q;
`ifdef STEP3_VALUE_OUT_EN
        point_value_d = point_value_q;
`endif
        case (state_q)
            IDLE: begin
                if (en_step3) begin
                    state_d = RUN;
                    p_d     = '0;
                    a_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                best_val_d = win_val;
                best_act_d = win_act;
                if (a_q == AW'(N_ACTION - 1)) begin
                    // Commit uses this edge's compare result, not the registered best.
                    for (int unsigned s = 0; s < N_STATE; s++) begin
                        alpha_out_d[p_q][s] = gamma_action_bilief[win_act][p_q][s];
                    end
                    action_out_d[p_q] = win_act;
`ifdef STEP3_VALUE_OUT_EN
                    point_value_d[p_q] = win_val;
`endif
                    a_d = '0;
                    if (p_q == PW'(N_POINT - 1)) begin
                        state_d   = DONE;
                        en_loop_d = 1'b1;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end else begin
                    a_d = a_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            p_q        <= '0;
            a_q        <= '0;
            best_val_q <= '0;
            best_act_q <= '0;
            busy_q     <= 1'b0;
            en_loop_q  <= 1'b0;
            for (int unsigned p = 0; p < N_POINT; p++) begin
                action_out_q[p] <= '0;
`ifdef STEP3_VALUE_OUT_EN
                point_value_q[p] <= '0;
`endif
                for (int unsigned s = 0; s < N_STATE; s++) begin
                    alpha_out_q[p][s] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            a_q          <= a_d;
            best_val_q   <= best_val_d;
            best_act_q   <= best_act_d;
            busy_q       <= busy_d;
            en_loop_q    <= en_loop_d;
            alpha_out_q  <= alpha_out_d;
            action_out_q <= action_out_d;
`ifdef STEP3_VALUE_OUT_EN
            point_value_q <= point_value_d;
`endif
        end
    end

    assign alpha_out  = alpha_out_q;
    assign action_out = action_out_q;
`ifdef STEP3_VALUE_OUT_EN
    assign point_value = point_value_q;
`endif
    assign busy    = busy_q;
    assign en_loop = en_loop_q;

endmodule

// File: tb/tb_step3_action_select.sv
// Bench for step3_action_select: directed cases plus random vectors against an argmax reference.
module tb_step3_action_select;

    localparam int NA = 3;
    localparam int NP = 16;
    localparam int NS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_step3 = 1'b0;
    logic [15:0] gam [NA][NP][NS];
    logic [15:0] bel [NP][NS];
    logic [15:0] alpha_out [NP][NS];
    logic [1:0]  action_out [NP];
`ifdef STEP3_VALUE_OUT_EN
    logic signed [33:0] point_value [NP];
`endif
    logic        busy;
    logic        en_loop;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    step3_action_select #(.N_ACTION(NA), .N_POINT(NP), .N_STATE(NS), .W(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .en_step3            (en_step3),
        .gamma_action_bilief (gam),
        .point_belief        (bel),
        .alpha_out           (alpha_out),
        .action_out          (action_out),
`ifdef STEP3_VALUE_OUT_EN
        .point_value         (point_value),
`endif
        .busy                (busy),
        .en_loop             (en_loop)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_belief();
        for (int p = 0; p < NP; p++) begin
            bel[p][0] = 16'(p * 16'h1000);
            bel[p][1] = 16'(16'hFFFF - p * 16'h1000);
        end
    endtask

    task automatic set_action(input int a, input logic [15:0] v0, input logic [15:0] v1);
        for (int p = 0; p < NP; p++) begin
            gam[a][p][0] = v0;
            gam[a][p][1] = v1;
        end
    endtask

    // Reference: full-precision dot per action, first strict maximum wins.
    task automatic check_outputs(input string tag);
        longint best, d;
        int     bact;
        for (int p = 0; p < NP; p++) begin
            best = 0;
            bact = 0;
            for (int a = 0; a < NA; a++) begin
                d = 0;
                for (int s = 0; s < NS; s++)
                    d += longint'($signed(gam[a][p][s])) * longint'(bel[p][s]);
                if (a == 0 || d > best) begin
                    best = d;
                    bact = a;
                end
            end
            check($sformatf("%s_act_p%0d", tag, p), longint'(action_out[p]), longint'(bact));
            for (int s = 0; s < NS; s++)
                check($sformatf("%s_alpha_p%0d_s%0d", tag, p, s),
                      longint'(alpha_out[p][s]), longint'(gam[bact][p][s]));
`ifdef STEP3_VALUE_OUT_EN
            check($sformatf("%s_val_p%0d", tag, p), longint'(point_value[p]), best);
`endif
        end
    endtask

    task automatic check_zero(input string tag);
        for (int p = 0; p < NP; p++) begin
            check($sformatf("%s_act0_p%0d", tag, p), longint'(action_out[p]), 0);
            check($sformatf("%s_alpha0_p%0d", tag, p), longint'({alpha_out[p][1], alpha_out[p][0]}), 0);
`ifdef STEP3_VALUE_OUT_EN
            check($sformatf("%s_val0_p%0d", tag, p), longint'(point_value[p]), 0);
`endif
        end
        check({tag, "_busy0"}, longint'(busy), 0);
        check({tag, "_enloop0"}, longint'(en_loop), 0);
    endtask

    // Sample k is taken at the falling edge after E(k); E0 is the start edge.
    task automatic run_sweep(input string tag, input bit hold);
        int first = -1;
        int nl = 0;
        int nb = 0;
        @(negedge clk);
        en_step3 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!hold) en_step3 = 1'b0;
            if (busy) nb++;
            if (en_loop) begin
                nl++;
                if (first < 0) first = k;
            end
            if (hold && k == 48) en_step3 = 1'b0;
        end
        check({tag, "_enloop_edge"}, first, 48);
        check({tag, "_enloop_count"}, nl, 1);
        check({tag, "_busy_cycles"}, nb, 49);
        check_outputs(tag);
    endtask

    initial begin
        set_belief();
        for (int a = 0; a < NA; a++) set_action(a, 16'h0, 16'h0);
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // T1 basic select
        set_action(0, 16'h0, 16'h0);
        set_action(1, 16'h0, 16'h0);
        set_action(2, 16'h0, 16'h1);
        run_sweep("t1", 1'b0);
        for (int p = 0; p < NP; p++)
            check($sformatf("t1_fixed_act_p%0d", p), longint'(action_out[p]), 2);

        // T2 ties
        for (int a = 0; a < NA; a++) set_action(a, 16'h1, 16'h1);
        run_sweep("t2", 1'b0);

        // T3 signed
        set_action(0, 16'hFFFF, 16'h0);
        set_action(1, 16'h0, 16'h0);
        set_action(2, 16'hFFFF, 16'hFFFF);
        run_sweep("t3", 1'b0);
        check("t3_fixed_p0", longint'(action_out[0]), 0);
        check("t3_fixed_p1", longint'(action_out[1]), 1);
        check("t3_fixed_p15", longint'(action_out[15]), 1);

        // T4 start held through the sweep, then a fresh pulse
        set_action(0, 16'h0, 16'h0);
        set_action(1, 16'h0, 16'h0);
        set_action(2, 16'h0, 16'h1);
        run_sweep("t4a", 1'b1);
        run_sweep("t4b", 1'b0);

        // T5 reset mid-sweep
        set_action(2, 16'h0, 16'h2);
        @(negedge clk);
        en_step3 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            en_step3 = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_zero("t5");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        begin
            int nl = 0;
            int nb = 0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (en_loop) nl++;
                if (busy) nb++;
            end
            check("t5_no_enloop", nl, 0);
            check("t5_no_busy", nb, 0);
        end
        run_sweep("t5_rerun", 1'b0);

        // Random vectors; narrow-range modes provoke ties
        for (int it = 0; it < 8; it++) begin
            int mode = int'($urandom_range(0, 2));
            for (int p = 0; p < NP; p++)
                for (int s = 0; s < NS; s++) begin
                    bel[p][s] = 16'($urandom);
                    for (int a = 0; a < NA; a++)
                        case (mode)
                            0: gam[a][p][s] = 16'($urandom);
                            1: gam[a][p][s] = 16'($urandom_range(0, 2));
                            default: gam[a][p][s] = 16'($urandom_range(0, 2) == 0 ? 16'hFFFF : 16'h0001);
                        endcase
                end
            run_sweep($sformatf("rnd%0d", it), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
